imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the core's combinational immediate generator.
- Extracts and sign/zero-extends RISC-V immediates for a configurable XLEN and carries a per-instruction tag.
- Adds an auto-decode mode (format chosen from the opcode) with an illegal-format flag.
- Sits between fetch/decode and execute: valid/ready handshake on both sides, flush support, one result per cycle when unstalled.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- PIPE_DEPTH, 1, register stages from input to output; legal range 1..4.
- TAG_W, 5, width of the sideband tag carried alongside each instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all in-flight entries.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_inst  in  32  instruction word.
- in_sel  in  3  format select: 0 I, 1 S, 2 B, 3 J, 4 U, 5 C (CSR zimm), 6 AUTO, 7 SHAMT.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_imm  out  XLEN  immediate.
- out_fmt  out  3  resolved format (never 6).
- out_illegal  out  1  AUTO mode found no immediate-bearing opcode.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset: all stage valids cleared. out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0. Reset mid-stream drops every in-flight beat, with no partial output.
- Extraction, combinational at the input, captured into stage 1:
  - I, S, B, J: sign bit inst[31] replicated to XLEN.
  - U: {inst[31:12],12'b0}, sign-extended from bit 31 when XLEN=64.
  - C: zero-extended inst[19:15].
  - SHAMT: zero-extended inst[24:20] when XLEN=32; inst[25:20] when XLEN=64.
- AUTO decode on inst[6:0]:
  - 0010011 with funct3 001/101 → SHAMT; other funct3 → I.
  - 0000011, 1100111 → I.
  - 1110011 → C if funct3[2]=1, else I.
  - 0100011 → S.
  - 1100011 → B.
  - 1101111 → J.
  - 0110111, 0010111 → U.
  - Any other opcode → imm=0, fmt=I, illegal=1.
  - Non-AUTO selects always give illegal=0.
- Stages 2..PIPE_DEPTH are pure register copies of {valid, imm, fmt, illegal, tag}.
- Latency: PIPE_DEPTH cycles from an accepted input to out_valid when out_ready=1. Throughput is 1 beat/cycle.
- Stall chain:
  - stage k advances when it is empty or stage k+1 advances.
  - Last stage advances when out_ready=1.
  - in_ready = stage-1 advance condition AND !flush AND !rst.
  - Accept = in_valid && in_ready.
- Output stability: while out_valid && !out_ready, all out_* hold their values unchanged.
- Flush: takes effect next edge. All valids cleared; in_valid in the same cycle is dropped (in_ready=0). The data registers may hold stale values, but out_valid=0.
- Simultaneous flush with out_valid && out_ready: the beat counts as consumed this cycle; nothing survives.
- Full pipeline with out_ready=0: in_ready=0. The first cycle out_ready=1, in_ready=1 combinationally, so no bubble is inserted.
- in_sel is sampled only on accept; changes while in_ready=0 have no effect.

Test Plan:
- XLEN=32, DEPTH=1: in_inst=0xFFF00093, sel=I, tag=3 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=0, out_tag=3.
- AUTO back-to-back, out_ready=1, in this order:
  - 0xFE000EE3 → 0xFFFFFFFC, fmt=B.
  - 0x0080006F → 0x00000008, fmt=J.
  - 0x002081B3 → imm=0, illegal=1.
  - Each result appears on consecutive cycles.
- XLEN=64, AUTO:
  - 0x800002B7 → out_imm=0xFFFFFFFF80000000, fmt=U.
  - slli 0x03F09093 → out_imm=0x3F, fmt=SHAMT.
- DEPTH=2, out_ready=0, stream 4 beats → in_ready drops after 2 accepted. out_imm is held on the first beat; releasing out_ready drains all 4 in order with no loss or duplication.
- DEPTH=3, 3 beats in flight, flush=1 for 1 cycle with in_valid=1 → out_valid stays 0. The flush-cycle beat is not delivered; a beat sent afterwards appears 3 cycles later.
- rst asserted mid-stream for 1 cycle → all out_* zero next cycle; no prior beat emerges afterwards.

Source files
------------

// File: rtl/imm_gen_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Pipelined RISC-V immediate generator. Extracts and extends
//                the immediate for a selected or opcode-decoded format, and
//                carries a sideband tag. Valid/ready on both sides, flush
//                support, and one result per cycle when not stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN       = 32,
    parameter int PIPE_DEPTH = 1,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] c_FMT_I     = 3'd0;
    localparam logic [2:0] c_FMT_S     = 3'd1;
    localparam logic [2:0] c_FMT_B     = 3'd2;
    localparam logic [2:0] c_FMT_J     = 3'd3;
    localparam logic [2:0] c_FMT_U     = 3'd4;
    localparam logic [2:0] c_FMT_C     = 3'd5;
    localparam logic [2:0] c_SEL_AUTO  = 3'd6;
    localparam logic [2:0] c_FMT_SHAMT = 3'd7;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [2:0]      w_fmt;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;
    logic            w_accept;

    logic [PIPE_DEPTH-1:0] r_valid;
    logic [PIPE_DEPTH-1:0] w_adv;
    logic [XLEN-1:0]       r_imm     [PIPE_DEPTH];
    logic [2:0]            r_fmt     [PIPE_DEPTH];
    logic                  r_illegal [PIPE_DEPTH];
    logic [TAG_W-1:0]      r_tag     [PIPE_DEPTH];

    assign w_opcode = in_inst[6:0];
    assign w_funct3 = in_inst[14:12];

    // Resolve the effective format: explicit selects pass through, AUTO decodes the opcode
    always_comb begin
        w_fmt     = in_sel;
        w_illegal = 1'b0;
        if (in_sel == c_SEL_AUTO) begin
            w_fmt = c_FMT_I;
            case (w_opcode)
                7'b0010011: begin
                    if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                        w_fmt = c_FMT_SHAMT;
                    end
                end
                7'b0000011, 7'b1100111: begin
                    w_fmt = c_FMT_I;
                end
                7'b1110011: begin
                    if (w_funct3[2]) begin
                        w_fmt = c_FMT_C;
                    end
                end
                7'b0100011:             w_fmt = c_FMT_S;
                7'b1100011:             w_fmt = c_FMT_B;
                7'b1101111:             w_fmt = c_FMT_J;
                7'b0110111, 7'b0010111: w_fmt = c_FMT_U;
                default:                w_illegal = 1'b1;
            endcase
        end
    end

    // Extract and extend the immediate for the resolved format
    always_comb begin
        w_imm = '0;
        case (w_fmt)
            c_FMT_I: w_imm = XLEN'($signed(in_inst[31:20]));
            c_FMT_S: w_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            c_FMT_B: w_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                            in_inst[11:8], 1'b0}));
            c_FMT_J: w_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                            in_inst[30:21], 1'b0}));
            c_FMT_U: w_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
            c_FMT_C: w_imm = XLEN'(in_inst[19:15]);
            c_FMT_SHAMT: begin
                if (XLEN == 64) begin
                    w_imm = XLEN'(in_inst[25:20]);
                end else begin
                    w_imm = XLEN'(in_inst[24:20]);
                end
            end
            default: w_imm = '0;
        endcase
        // An undecodable opcode yields a zero immediate regardless of format
        if (w_illegal) begin
            w_imm = '0;
        end
    end

    // Stage k may move when any stage from k to the output is empty, or the
    // consumer takes the output; this is the unrolled stall chain.
    generate
        for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_adv
            assign w_adv[k] = out_ready || !(&r_valid[PIPE_DEPTH-1:k]);
        end
    endgenerate

    assign in_ready = w_adv[0] && !flush && !rst;
    assign w_accept = in_valid && in_ready;

    // Pipeline registers: stage 0 captures accepted beats, later stages copy forward
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_imm[k]     <= '0;
                r_fmt[k]     <= '0;
                r_illegal[k] <= 1'b0;
                r_tag[k]     <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_valid[0] <= w_accept;
                if (w_accept) begin
                    r_imm[0]     <= w_imm;
                    r_fmt[0]     <= w_fmt;
                    r_illegal[0] <= w_illegal;
                    r_tag[0]     <= in_tag;
                end
            end
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                if (w_adv[k]) begin
                    r_valid[k]   <= r_valid[k-1];
                    r_imm[k]     <= r_imm[k-1];
                    r_fmt[k]     <= r_fmt[k-1];
                    r_illegal[k] <= r_illegal[k-1];
                    r_tag[k]     <= r_tag[k-1];
                end
            end
            // Flush only kills validity; stale data behind a low valid is harmless
            if (flush) begin
                r_valid <= '0;
            end
        end
    end

    assign out_valid   = r_valid[PIPE_DEPTH-1];
    assign out_imm     = r_imm[PIPE_DEPTH-1];
    assign out_fmt     = r_fmt[PIPE_DEPTH-1];
    assign out_illegal = r_illegal[PIPE_DEPTH-1];
    assign out_tag     = r_tag[PIPE_DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Scoreboard bench for imm_gen_pipe. Three instances:
//                d0 = XLEN 32 / depth 1, d1 = XLEN 64 / depth 2,
//                d2 = XLEN 32 / depth 3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [4:0]  tag;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush     [3];
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [31:0] in_inst   [3];
    logic [2:0]  in_sel    [3];
    logic [4:0]  in_tag    [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [63:0] out_imm   [3];
    logic [2:0]  out_fmt   [3];
    logic        out_illegal [3];
    logic [4:0]  out_tag   [3];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int pend  [3];
    bit chk_lat = 1'b0;

    logic [31:0] bi_inst [64];
    logic [2:0]  bi_sel  [64];
    logic [4:0]  bi_tag  [64];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model written directly from the immediate layouts
    function automatic exp_t model(input logic [31:0] inst, input logic [2:0] sel, input bit x64);
        exp_t        e;
        logic [2:0]  f;
        logic [63:0] v;
        e.ill = 1'b0;
        e.acc = 0;
        e.tag = '0;
        f = sel;
        if (sel == 3'd6) begin
            case (inst[6:0])
                7'h13:        f = (inst[14:12] == 3'd1 || inst[14:12] == 3'd5) ? 3'd7 : 3'd0;
                7'h03, 7'h67: f = 3'd0;
                7'h73:        f = inst[14] ? 3'd5 : 3'd0;
                7'h23:        f = 3'd1;
                7'h63:        f = 3'd2;
                7'h6F:        f = 3'd3;
                7'h37, 7'h17: f = 3'd4;
                default: begin f = 3'd0; e.ill = 1'b1; end
            endcase
        end
        case (f)
            3'd0: v = {{52{inst[31]}}, inst[31:20]};
            3'd1: v = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            3'd2: v = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            3'd3: v = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            3'd4: v = {{32{inst[31]}}, inst[31:12], 12'b0};
            3'd5: v = {59'b0, inst[19:15]};
            default: v = x64 ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]};
        endcase
        if (e.ill) v = '0;
        if (!x64) v[63:32] = '0;
        e.imm = v;
        e.fmt = f;
        return e;
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int XL = (g == 1) ? 64 : 32;
            localparam int DP = g + 1;

            logic [XL-1:0] imm_l;
            exp_t          q [$];
            logic          held     = 1'b0;
            logic          rst_seen = 1'b0;
            logic [63:0]   h_imm;
            logic [2:0]    h_fmt;
            logic          h_ill;
            logic [4:0]    h_tag;

            imm_gen_pipe #(.XLEN(XL), .PIPE_DEPTH(DP), .TAG_W(5)) u_dut (
                .clk         (clk),
                .rst         (rst),
                .flush       (flush[g]),
                .in_valid    (in_valid[g]),
                .in_ready    (in_ready[g]),
                .in_inst     (in_inst[g]),
                .in_sel      (in_sel[g]),
                .in_tag      (in_tag[g]),
                .out_valid   (out_valid[g]),
                .out_ready   (out_ready[g]),
                .out_imm     (imm_l),
                .out_fmt     (out_fmt[g]),
                .out_illegal (out_illegal[g]),
                .out_tag     (out_tag[g])
            );

            assign out_imm[g] = 64'(imm_l);

            // Scoreboard monitor: reset/hold checks, pop on handshake, push on accept
            always @(negedge clk) begin
                exp_t e;
                if (rst_seen) begin
                    check_val($sformatf("d%0d_rst_valid", g), 64'(out_valid[g]), 64'd0);
                    check_val($sformatf("d%0d_rst_imm", g), out_imm[g], 64'd0);
                    check_val($sformatf("d%0d_rst_fmt", g), 64'(out_fmt[g]), 64'd0);
                    check_val($sformatf("d%0d_rst_ill", g), 64'(out_illegal[g]), 64'd0);
                    check_val($sformatf("d%0d_rst_tag", g), 64'(out_tag[g]), 64'd0);
                end
                if (held) begin
                    check_val($sformatf("d%0d_hold_valid", g), 64'(out_valid[g]), 64'd1);
                    check_val($sformatf("d%0d_hold_imm", g), out_imm[g], h_imm);
                    check_val($sformatf("d%0d_hold_fmt", g), 64'(out_fmt[g]), 64'(h_fmt));
                    check_val($sformatf("d%0d_hold_ill", g), 64'(out_illegal[g]), 64'(h_ill));
                    check_val($sformatf("d%0d_hold_tag", g), 64'(out_tag[g]), 64'(h_tag));
                end
                rst_seen <= rst;
                held     <= out_valid[g] && !out_ready[g] && !flush[g] && !rst;
                h_imm    <= out_imm[g];
                h_fmt    <= out_fmt[g];
                h_ill    <= out_illegal[g];
                h_tag    <= out_tag[g];
                if (rst) begin
                    q.delete();
                end else begin
                    if (out_valid[g] && out_ready[g]) begin
                        if (q.size() == 0) begin
                            check_val($sformatf("d%0d_spurious_out", g), 64'(q.size()), 64'd1);
                        end else begin
                            e = q.pop_front();
                            check_val($sformatf("d%0d_imm", g), out_imm[g], e.imm);
                            check_val($sformatf("d%0d_fmt", g), 64'(out_fmt[g]), 64'(e.fmt));
                            check_val($sformatf("d%0d_ill", g), 64'(out_illegal[g]), 64'(e.ill));
                            check_val($sformatf("d%0d_tag", g), 64'(out_tag[g]), 64'(e.tag));
                            if (chk_lat) begin
                                check_val($sformatf("d%0d_latency", g), 64'(cyc - e.acc), 64'(DP));
                            end
                        end
                    end
                    if (flush[g]) q.delete();
                    if (in_valid[g] && in_ready[g]) begin
                        e     = model(in_inst[g], in_sel[g], XL == 64);
                        e.tag = in_tag[g];
                        e.acc = cyc;
                        q.push_back(e);
                    end
                end
                pend[g] = q.size();
            end
        end
    endgenerate

    // Send beats bi_*[start..stop-1] back-to-back; called just after a rising edge
    task automatic run_stream(input int d, input int start, input int stop, input bit rnd);
        int k = start;
        int guard = 0;
        while (k < stop && guard < 2000) begin
            in_valid[d] = 1'b1;
            in_inst[d]  = bi_inst[k];
            in_sel[d]   = bi_sel[k];
            in_tag[d]   = bi_tag[k];
            if (rnd) out_ready[d] = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready[d]) k++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid[d] = 1'b0;
        if (k < stop) check_val("stream_timeout", 64'(k), 64'(stop));
    endtask

    task automatic drain(input int d);
        out_ready[d] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_val($sformatf("d%0d_pending", d), 64'(pend[d]), 64'd0);
    endtask

    task automatic set_beat(input int i, input logic [31:0] inst, input logic [2:0] sel,
                            input logic [4:0] tag);
        bi_inst[i] = inst;
        bi_sel[i]  = sel;
        bi_tag[i]  = tag;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [6:0] ops [9];
        int k;
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            flush[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b1;
            in_inst[d] = '0; in_sel[d] = '0; in_tag[d] = '0; pend[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // d0: single I-type beat, latency 1
        chk_lat = 1'b1;
        set_beat(0, 32'hFFF00093, 3'd0, 5'd3);
        run_stream(0, 0, 1, 1'b0);
        drain(0);

        // d0: AUTO back-to-back B, J, illegal
        set_beat(0, 32'hFE000EE3, 3'd6, 5'd1);
        set_beat(1, 32'h0080006F, 3'd6, 5'd2);
        set_beat(2, 32'h002081B3, 3'd6, 5'd3);
        set_beat(3, 32'h03F09093, 3'd7, 5'd4);
        set_beat(4, 32'h3402D073, 3'd6, 5'd5);
        run_stream(0, 0, 5, 1'b0);
        drain(0);

        // d1 (XLEN 64): U sign-extension and 6-bit shift amounts
        set_beat(0, 32'h800002B7, 3'd6, 5'd7);
        set_beat(1, 32'h03F09093, 3'd6, 5'd8);
        set_beat(2, 32'h4050D093, 3'd6, 5'd9);
        set_beat(3, 32'hFE112E23, 3'd6, 5'd10);
        set_beat(4, 32'h34029073, 3'd6, 5'd11);
        set_beat(5, 32'h03F09093, 3'd7, 5'd12);
        set_beat(6, 32'h800002B7, 3'd4, 5'd13);
        run_stream(1, 0, 7, 1'b0);
        drain(1);

        // d1: stall with out_ready low, then release and drain four beats
        chk_lat = 1'b0;
        for (int i = 0; i < 4; i++) set_beat(i, 32'hFFF00013 - 32'(i << 20), 3'd0, 5'(16 + i));
        out_ready[1] = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid[1] = 1'b1;
            in_inst[1]  = bi_inst[k];
            in_sel[1]   = bi_sel[k];
            in_tag[1]   = bi_tag[k];
            @(negedge clk);
            if (in_ready[1]) k++;
            @(posedge clk); #1;
        end
        check_val("stall_accepted", 64'(k), 64'd2);
        @(negedge clk);
        check_val("stall_in_ready", 64'(in_ready[1]), 64'd0);
        @(posedge clk); #1;
        out_ready[1] = 1'b1;
        #1 check_val("release_in_ready", 64'(in_ready[1]), 64'd1);
        run_stream(1, k, 4, 1'b0);
        drain(1);

        // d2: fill three beats, flush with a beat offered, then one more beat
        out_ready[2] = 1'b0;
        for (int i = 0; i < 3; i++) set_beat(i, 32'h00100093 + 32'(i << 20), 3'd0, 5'(20 + i));
        set_beat(3, 32'h00500093, 3'd0, 5'd30);
        set_beat(4, 32'h00700023, 3'd1, 5'd31);
        run_stream(2, 0, 3, 1'b0);
        flush[2] = 1'b1;
        in_valid[2] = 1'b1; in_inst[2] = bi_inst[3]; in_sel[2] = bi_sel[3]; in_tag[2] = bi_tag[3];
        @(negedge clk);
        check_val("flush_in_ready", 64'(in_ready[2]), 64'd0);
        @(posedge clk); #1;
        flush[2] = 1'b0; in_valid[2] = 1'b0; out_ready[2] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_val("flush_out_valid", 64'(out_valid[2]), 64'd0);
        end
        @(posedge clk); #1;
        chk_lat = 1'b1;
        run_stream(2, 4, 5, 1'b0);
        drain(2);
        chk_lat = 1'b0;

        // d2: reset mid-stream drops in-flight beats
        run_stream(2, 0, 2, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_val("post_rst_valid", 64'(out_valid[2]), 64'd0);
        end
        @(posedge clk); #1;
        check_val("post_rst_pending", 64'(pend[2]), 64'd0);

        // Random formats and random back-pressure on every instance
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 40; i++) begin
                bi_inst[i] = $urandom;
                bi_sel[i]  = 3'($urandom_range(0, 7));
                bi_tag[i]  = 5'($urandom);
                if (bi_sel[i] == 3'd6 && $urandom_range(0, 3) != 0)
                    bi_inst[i][6:0] = ops[$urandom_range(0, 8)];
            end
            run_stream(d, 0, 40, 1'b1);
            drain(d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
